sd_serialize_n: RTL and testbench
=================================

Name: sd_serialize_n

Overview:
- Parametrised srdy/drdy serializer. Each input token of `width` bits is split into up to `ratio` beats of `width/ratio` bits.
- Beat order is selectable (MSB-first or LSB-first). Each token can carry its own beat count, so short tokens use fewer beats.
- The block holds its own copy of the token, so the upstream stage is released on accept. Back-to-back tokens stream with zero bubble cycles.
- Sits between a wide producer and a narrow link or bus.

Parameters:
- width, 32, input token width in bits. Must be an integer multiple of ratio.
- ratio, 4, maximum beats per token. Must be 2 or more.
- msb_first, 1, beat order. 1 = most-significant slice first; 0 = least-significant slice first.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- c_srdy  input  1  consumer-side token valid
- c_drdy  output  1  consumer-side ready (block accepts the token)
- c_data  input  width  token data
- c_len  input  lw = max(1,$clog2(ratio))  number of beats minus 1; sampled with c_data
- p_srdy  output  1  producer-side beat valid
- p_drdy  input  1  producer-side ready
- p_data  output  width/ratio  current beat
- p_last  output  1  current beat is the final beat of its token
- p_beat  output  lw  index of the current beat within its token, starting at 0

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Beat width and slices: bw = width/ratio. Slice k = c_data[(k+1)*bw-1 : k*bw].
- Beat order, msb_first=1: beat i is slice ratio-1-i. A short token sends the top len+1 slices.
- Beat order, msb_first=0: beat i is slice i. A short token sends the bottom len+1 slices.
- Length clamp: effective length len_e = min(c_len, ratio-1). This only matters for non-power-of-2 ratio.
- Storage: holding register of width bits, beat counter cnt, stored len_e, and one state bit.
- States:
  - EMPTY: p_srdy=0.
  - ACTIVE: p_srdy=1, p_data=selected slice for cnt, p_beat=cnt, p_last=(cnt==len_e).
- Handshake outputs:
  - c_drdy = (state==EMPTY) | (p_srdy & p_drdy & p_last). It is combinational from p_drdy.
  - p_srdy, p_data, p_last and p_beat are registered or decoded from registers only. None depends combinationally on c_srdy.
- Accept: c_srdy & c_drdy. On accept, the holding register is loaded, cnt=0, len_e is stored, and state goes to ACTIVE.
- Latency: the first beat is valid the cycle after accept.
- Beat transfer: p_srdy & p_drdy.
  - Not last: cnt increments.
  - Last with a simultaneous accept: reload with the new token, cnt=0, stay ACTIVE. There is no bubble.
  - Last with no accept: go to EMPTY.
- Backpressure: while p_srdy=1 and p_drdy=0, p_data, p_last and p_beat hold stable. No beat is dropped or duplicated.
- Single-beat token (len_e=0): p_last=1 on beat 0. Sustained throughput is then 1 token per cycle.
- c_len and c_data are ignored when no accept occurs.
- Reset values: state EMPTY, cnt=0, holding register=0. So p_srdy=0, p_last=0, p_beat=0, p_data=0, and c_drdy=1 (via EMPTY).
- Reset mid-token: any partially sent token is discarded. The next accepted token starts at beat 0.
- Full/empty: exactly one token is in flight. Bandwidth is width bits per len_e+1 cycles when p_drdy=1.

Test Plan:
- Single token, defaults: c_data=0xAABBCCDD, c_len=3, p_drdy=1.
  - p_data is AA, BB, CC, DD on cycles 1-4.
  - p_beat is 0..3; p_last=1 only on DD.
  - c_drdy=0 on cycles 1-3 and 1 on cycle 4.
- Back-to-back: tokens 0x11223344 and 0x55667788, c_len=3, c_srdy held high.
  - 8 consecutive beats 11,22,33,44,55,66,77,88 with no gap.
  - The second accept happens in the cycle beat 44 transfers.
- Backpressure: 0xAABBCCDD with p_drdy pattern 1,0,0,1,1,0,1.
  - p_data is held at BB through both stall cycles.
  - Exactly 4 beats are transferred, in order.
- Short tokens:
  - c_len=1 with 0xDEADBEEF gives DE, AD(last).
  - c_len=0 gives DE(last).
  - width=24, ratio=3, c_len=3 clamps to 3 beats.
- LSB-first: msb_first=0, 0xAABBCCDD, c_len=3 gives DD, CC, BB, AA(last). c_len=1 gives DD, CC(last).
- Reset mid-token: assert reset after beat BB of 0xAABBCCDD.
  - Next cycle: p_srdy=0, c_drdy=1.
  - Next token 0x01020304 emits 01 first with p_beat=0.

Source files
------------

// File: rtl/sd_serialize_n.sv
`default_nettype none
// ============================================================================
//  sd_serialize_n : srdy/drdy serializer, one WIDTH token into up to RATIO beats
//  Revision 1.0
// ============================================================================
module sd_serialize_n #(
   parameter int WIDTH     = 32,
   parameter int RATIO     = 4,
   parameter int MSB_FIRST = 1,
   localparam int LW       = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1,
   localparam int BW       = WIDTH / RATIO
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             c_srdy,
   output logic             c_drdy,
   input  logic [WIDTH-1:0] c_data,
   input  logic [LW-1:0]    c_len,
   output logic             p_srdy,
   input  logic             p_drdy,
   output logic [BW-1:0]    p_data,
   output logic             p_last,
   output logic [LW-1:0]    p_beat
);

   typedef enum logic [0:0] {
      EMPTY  = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [LW-1:0]    cnt_q, cnt_d;
   logic [LW-1:0]    len_q, len_d;
   logic [LW-1:0]    len_e;
   logic [LW-1:0]    sel;
   logic             xfer;
   logic             accept;

   // Clamping only matters when RATIO does not fill the c_len code space.
   if (RATIO == (1 << LW)) begin : g_len_pass
      assign len_e = c_len;
   end else begin : g_len_clamp
      assign len_e = (c_len > LW'(RATIO - 1)) ? LW'(RATIO - 1) : c_len;
   end

   if (MSB_FIRST != 0) begin : g_msb_first
      assign sel = LW'(RATIO - 1) - cnt_q;
   end else begin : g_lsb_first
      assign sel = cnt_q;
   end

   assign p_srdy = (state_q == ACTIVE);
   assign p_last = p_srdy & (cnt_q == len_q);
   assign p_beat = cnt_q;
   assign xfer   = p_srdy & p_drdy;
   assign c_drdy = ~p_srdy | (xfer & p_last);
   assign accept = c_srdy & c_drdy;

   always_comb begin
      p_data = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (sel == LW'(k)) p_data = hold_q[k*BW +: BW];
      end
   end

   // A final beat and a new accept can coincide: the reload wins, giving no bubble.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      if (accept) begin
         state_d = ACTIVE;
         hold_d  = c_data;
         cnt_d   = '0;
         len_d   = len_e;
      end else if (xfer && p_last) begin
         state_d = EMPTY;
         cnt_d   = '0;
      end else if (xfer) begin
         cnt_d   = cnt_q + LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         hold_q  <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sd_serialize_n.sv
`default_nettype none
// ============================================================================
//  tb_sd_serialize_n : bench for sd_serialize_n (default, LSB-first, 24/3 clamp)
//  Revision 1.0
// ============================================================================
module tb_sd_serialize_n;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // Default instance: 32 bits, 4 beats, MSB first
   logic        c_srdy = 1'b0, c_drdy;
   logic [31:0] c_data = '0;
   logic [1:0]  c_len = '0;
   logic        p_srdy, p_drdy = 1'b0, p_last;
   logic [7:0]  p_data;
   logic [1:0]  p_beat;

   // LSB-first instance
   logic        l_srdy = 1'b0, l_drdy, l_p_srdy, l_p_last;
   logic [31:0] l_data = '0;
   logic [1:0]  l_len = '0, l_p_beat;
   logic [7:0]  l_p_data;

   // 24-bit / 3-beat instance
   logic        k_srdy = 1'b0, k_drdy, k_p_srdy, k_p_last;
   logic [23:0] k_data = '0;
   logic [1:0]  k_len = '0, k_p_beat;
   logic [7:0]  k_p_data;

   sd_serialize_n #(.WIDTH(32), .RATIO(4), .MSB_FIRST(1)) dut (
      .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
      .c_len(c_len), .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data),
      .p_last(p_last), .p_beat(p_beat));

   sd_serialize_n #(.WIDTH(32), .RATIO(4), .MSB_FIRST(0)) dut_l (
      .clk(clk), .reset(reset), .c_srdy(l_srdy), .c_drdy(l_drdy), .c_data(l_data),
      .c_len(l_len), .p_srdy(l_p_srdy), .p_drdy(1'b1), .p_data(l_p_data),
      .p_last(l_p_last), .p_beat(l_p_beat));

   sd_serialize_n #(.WIDTH(24), .RATIO(3), .MSB_FIRST(1)) dut_k (
      .clk(clk), .reset(reset), .c_srdy(k_srdy), .c_drdy(k_drdy), .c_data(k_data),
      .c_len(k_len), .p_srdy(k_p_srdy), .p_drdy(1'b1), .p_data(k_p_data),
      .p_last(k_p_last), .p_beat(k_p_beat));

   int n_checks = 0;
   int n_fail   = 0;
   int n_beats  = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected beat: {last, beat, data}
   logic [10:0] sb_q[$];

   // Stimulus table: token, length and the beats it must produce (left-justified, in order)
   typedef struct {
      logic [31:0] data;
      logic [1:0]  len;
      logic [31:0] exp;
      int          n;
   } vec_t;
   vec_t tbl[8];

   // Monitor: scoreboard pop on every transfer, and stability while stalled
   logic        stall_prev = 1'b0;
   logic [11:0] held;
   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            check("hold_stable", {p_srdy, p_last, p_beat, p_data}, held);
         if (p_srdy && p_drdy) begin
            n_beats++;
            if (sb_q.size() == 0) check("unexpected_beat", {p_last, p_beat, p_data}, 11'h7ff);
            else check("beat", {p_last, p_beat, p_data}, sb_q.pop_front());
         end
         stall_prev = p_srdy && !p_drdy;
         held       = {p_srdy, p_last, p_beat, p_data};
      end
   end

   logic rnd_bp = 1'b0;
   always @(posedge clk) begin
      if (rnd_bp) begin
         #1;
         p_drdy = 1'($urandom_range(0, 1));
      end
   end

   // Offer one token; push its beats when the accept is certain; return p_data at accept.
   task automatic drive_token(input vec_t v, output logic [7:0] acc_pd);
      int t = 0;
      c_srdy = 1'b1;
      c_data = v.data;
      c_len  = v.len;
      acc_pd = 8'h00;
      forever begin
         @(negedge clk);
         if (c_drdy) break;
         t++;
         if (t > 200) begin
            check("accept_timeout", 1, 0);
            c_srdy = 1'b0;
            return;
         end
      end
      acc_pd = p_data;
      for (int i = 0; i < v.n; i++)
         sb_q.push_back({(i == v.n - 1), 2'(i), v.exp[31 - 8*i -: 8]});
      @(posedge clk);
      #1;
      c_srdy = 1'b0;
   endtask

   task automatic drain;
      int t = 0;
      while (sb_q.size() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain", 64'(sb_q.size()), 0);
   endtask

   logic [7:0]  pd;
   logic [6:0]  pat;
   logic [31:0] ex;
   int          b0;
   vec_t        v;

   initial begin
      tbl[0] = '{32'h11223344, 2'd3, 32'h11223344, 4};
      tbl[1] = '{32'hDEADBEEF, 2'd1, 32'hDEAD0000, 2};
      tbl[2] = '{32'hDEADBEEF, 2'd0, 32'hDE000000, 1};
      tbl[3] = '{32'h0F1E2D3C, 2'd2, 32'h0F1E2D00, 3};
      tbl[4] = '{32'hCAFEF00D, 2'd3, 32'hCAFEF00D, 4};
      tbl[5] = '{32'h12345678, 2'd0, 32'h12000000, 1};
      tbl[6] = '{32'h9ABCDEF0, 2'd0, 32'h9A000000, 1};
      tbl[7] = '{32'h80000001, 2'd3, 32'h80000001, 4};

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_p_srdy", p_srdy, 0);
      check("rst_p_last", p_last, 0);
      check("rst_p_beat", p_beat, 0);
      check("rst_p_data", p_data, 0);
      check("rst_c_drdy", c_drdy, 1);
      p_drdy = 1'b1;

      // Single token: cycle-exact data and c_drdy
      v = '{32'hAABBCCDD, 2'd3, 32'hAABBCCDD, 4};
      drive_token(v, pd);
      ex = 32'hAABBCCDD;
      for (int k = 1; k <= 4; k++) begin
         check("single_c_drdy", c_drdy, (k == 4));
         check("single_p_data", p_data, ex[31 - 8*(k-1) -: 8]);
         @(posedge clk);
         #1;
      end
      check("single_idle", p_srdy, 0);
      drain();

      // Back-to-back: second accept lands on beat 44, then 55 follows without a gap
      v = '{32'h11223344, 2'd3, 32'h11223344, 4};
      drive_token(v, pd);
      v = '{32'h55667788, 2'd3, 32'h55667788, 4};
      drive_token(v, pd);
      check("b2b_accept_on_44", pd, 8'h44);
      check("b2b_no_bubble", {p_srdy, p_beat, p_data}, {1'b1, 2'd0, 8'h55});
      drain();

      // Backpressure pattern 1,0,0,1,1,0,1
      b0  = n_beats;
      pat = 7'b1001101;
      v = '{32'hAABBCCDD, 2'd3, 32'hAABBCCDD, 4};
      drive_token(v, pd);
      for (int k = 0; k < 7; k++) begin
         p_drdy = pat[6 - k];
         if (k == 2) check("bp_held_bb", p_data, 8'hBB);
         @(posedge clk);
         #1;
      end
      p_drdy = 1'b1;
      check("bp_beats", 64'(n_beats - b0), 4);
      check("bp_idle", p_srdy, 0);
      drain();

      // Table, streamed with p_drdy=1, then with random backpressure
      for (int i = 0; i < 8; i++) drive_token(tbl[i], pd);
      drain();
      rnd_bp = 1'b1;
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < 8; i++) drive_token(tbl[i], pd);
      rnd_bp = 1'b0;
      @(posedge clk);
      #2;
      p_drdy = 1'b1;
      drain();

      // Reset mid-token after beat BB
      v = '{32'hAABBCCDD, 2'd3, 32'hAABBCCDD, 4};
      drive_token(v, pd);
      for (int t = 0; t < 10 && p_data != 8'hBB; t++) @(negedge clk);
      check("mid_saw_bb", p_data, 8'hBB);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb_q.delete();
      check("mid_p_srdy", p_srdy, 0);
      check("mid_c_drdy", c_drdy, 1);
      v = '{32'h01020304, 2'd3, 32'h01020304, 4};
      drive_token(v, pd);
      check("mid_restart", {p_beat, p_data}, {2'd0, 8'h01});
      drain();

      // LSB-first instance
      check("lsb_c_drdy", l_drdy, 1);
      for (int s = 0; s < 2; s++) begin
         l_srdy = 1'b1;
         l_data = 32'hAABBCCDD;
         l_len  = (s == 0) ? 2'd3 : 2'd1;
         ex     = 32'hDDCCBBAA;
         @(posedge clk);
         #1;
         l_srdy = 1'b0;
         for (int i = 0; i <= int'(l_len); i++) begin
            check("lsb_beat", {l_p_srdy, l_p_last, l_p_beat, l_p_data},
                  {1'b1, (i == int'(l_len)), 2'(i), ex[31 - 8*i -: 8]});
            @(posedge clk);
            #1;
         end
         check("lsb_idle", l_p_srdy, 0);
      end

      // 24/3 instance: c_len=3 clamps to three beats; c_len=1 gives two
      for (int s = 0; s < 2; s++) begin
         k_srdy = 1'b1;
         k_data = 24'hABCDEF;
         k_len  = (s == 0) ? 2'd3 : 2'd1;
         ex     = 32'hABCDEF00;
         b0     = (s == 0) ? 3 : 2;
         @(posedge clk);
         #1;
         k_srdy = 1'b0;
         for (int i = 0; i < b0; i++) begin
            check("clamp_beat", {k_p_srdy, k_p_last, k_p_beat, k_p_data},
                  {1'b1, (i == b0 - 1), 2'(i), ex[31 - 8*i -: 8]});
            @(posedge clk);
            #1;
         end
         check("clamp_idle", k_p_srdy, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
